// File: rtl/mux_scan_n.sv
// mux_scan_n: registered N-channel multiplexer with manual select and
// timed auto-scan (dwell counter per channel, hold/freeze, wrap pulse).
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | disabled; valid low, data/chan/count hold
// S_MANUAL | data_out follows channel sel; out-of-range sel flags sel_err
// S_SCAN   | dwell counter runs, chan_out advances every DWELL cycles
// S_FROZEN | scan position (count and chan) held, data still tracks
module mux_scan_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 16,
  parameter int SW       = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      mode,
  input  logic                      hold,
  input  logic [SW-1:0]             sel,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]          data_out,
  output logic [SW-1:0]             chan_out,
  output logic                      valid,
  output logic                      wrap,
  output logic                      sel_err
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MANUAL, S_SCAN, S_FROZEN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    chan_q, chan_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             sel_err_q, sel_err_d;
  logic [WIDTH-1:0] chan_data [CHANNELS];

  // unpack the flat input bus into one word per channel
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      chan_data[k] = data_in[k*WIDTH +: WIDTH];
    end
  end

  // next-state selection, fixed priority en > mode > hold
  always_comb begin
    state_d = state_q;
    if (!en)       state_d = S_IDLE;
    else if (!mode) state_d = S_MANUAL;
    else if (hold)  state_d = S_FROZEN;
    else            state_d = S_SCAN;
  end

  // output and scan-position update for the state being entered
  always_comb begin
    cnt_d      = cnt_q;
    chan_d     = chan_q;
    data_out_d = data_out_q;
    valid_d    = valid_q;
    wrap_d     = 1'b0;
    sel_err_d  = sel_err_q;
    case (state_d)
      S_IDLE: begin
        valid_d   = 1'b0;
        sel_err_d = 1'b0;
      end
      S_MANUAL: begin
        if (int'(sel) < CHANNELS) begin
          chan_d     = sel;
          data_out_d = chan_data[sel];
          valid_d    = 1'b1;
          sel_err_d  = 1'b0;
        end else begin
          data_out_d = '0;
          valid_d    = 1'b0;
          sel_err_d  = 1'b1;
        end
      end
      S_SCAN: begin
        // a fresh scan starts at count 0 on the current channel; coming
        // back from FROZEN resumes from the held count instead
        if (state_q == S_IDLE || state_q == S_MANUAL) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(DWELL - 1)) begin
          cnt_d = '0;
          if (chan_q == SW'(CHANNELS - 1)) begin
            chan_d = '0;
            wrap_d = 1'b1;
          end else begin
            chan_d = chan_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        data_out_d = chan_data[chan_d];
        valid_d    = 1'b1;
        sel_err_d  = 1'b0;
      end
      S_FROZEN: begin
        data_out_d = chan_data[chan_q];
        valid_d    = 1'b1;
        sel_err_d  = 1'b0;
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      chan_q     <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      chan_q     <= chan_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      wrap_q     <= wrap_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign data_out = data_out_q;
  assign chan_out = chan_q;
  assign valid    = valid_q;
  assign wrap     = wrap_q;
  assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: three instances (4ch/dwell 3, 3ch/dwell 3,
// 5ch/dwell 1) share stimulus and are compared against a behavioural model.
module tb_mux_scan_n;

  localparam int NI = 3;
  localparam int CH [NI] = '{4, 3, 5};
  localparam int DW [NI] = '{3, 3, 1};
  localparam int SWI[NI] = '{2, 2, 3};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0, mode = 1'b0, hold = 1'b0;
  logic [3:0]   sel_bus = '0;
  logic [127:0] data_bus = '0;

  logic [7:0] dout0, dout1, dout2;
  logic [1:0] chan0, chan1;
  logic [2:0] chan2;
  logic       val0, val1, val2, wr0, wr1, wr2, err0, err1, err2;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state per instance
  int m_dout[NI], m_chan[NI], m_cnt[NI];
  int m_valid[NI], m_wrap[NI], m_err[NI], m_run[NI];

  always #5 clk = ~clk;

  mux_scan_n #(.WIDTH(8), .CHANNELS(4), .DWELL(3)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .hold(hold),
    .sel(sel_bus[1:0]), .data_in(data_bus[31:0]), .data_out(dout0),
    .chan_out(chan0), .valid(val0), .wrap(wr0), .sel_err(err0));

  mux_scan_n #(.WIDTH(8), .CHANNELS(3), .DWELL(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .hold(hold),
    .sel(sel_bus[1:0]), .data_in(data_bus[23:0]), .data_out(dout1),
    .chan_out(chan1), .valid(val1), .wrap(wr1), .sel_err(err1));

  mux_scan_n #(.WIDTH(8), .CHANNELS(5), .DWELL(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .hold(hold),
    .sel(sel_bus[2:0]), .data_in(data_bus[39:0]), .data_out(dout2),
    .chan_out(chan2), .valid(val2), .wrap(wr2), .sel_err(err2));

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int chan_byte(input int k);
    return int'(data_bus[k*8 +: 8]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_dout[i] = 0; m_chan[i] = 0; m_cnt[i] = 0;
      m_valid[i] = 0; m_wrap[i] = 0; m_err[i] = 0; m_run[i] = 0;
    end
  endtask

  // one clock of intended behaviour, from the current inputs
  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      int s;
      m_wrap[i] = 0;
      if (!en) begin
        m_valid[i] = 0; m_err[i] = 0; m_run[i] = 0;
      end else if (!mode) begin
        s = int'(sel_bus) % (1 << SWI[i]);
        m_run[i] = 0;
        if (s < CH[i]) begin
          m_dout[i] = chan_byte(s); m_chan[i] = s; m_valid[i] = 1; m_err[i] = 0;
        end else begin
          m_dout[i] = 0; m_valid[i] = 0; m_err[i] = 1;
        end
      end else begin
        if (!hold) begin
          if (!m_run[i]) m_cnt[i] = 0;
          else if (m_cnt[i] == DW[i] - 1) begin
            m_cnt[i] = 0;
            m_chan[i] = (m_chan[i] + 1) % CH[i];
            m_wrap[i] = (m_chan[i] == 0) ? 1 : 0;
          end else m_cnt[i] = m_cnt[i] + 1;
        end
        m_run[i] = 1;
        m_dout[i] = chan_byte(m_chan[i]); m_valid[i] = 1; m_err[i] = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int d, c, v, w, e;
    for (int i = 0; i < NI; i++) begin
      case (i)
        0: begin d = int'(dout0); c = int'(chan0); v = int'(val0); w = int'(wr0); e = int'(err0); end
        1: begin d = int'(dout1); c = int'(chan1); v = int'(val1); w = int'(wr1); e = int'(err1); end
        default: begin d = int'(dout2); c = int'(chan2); v = int'(val2); w = int'(wr2); e = int'(err2); end
      endcase
      check($sformatf("%s.u%0d.data_out", tag, i), d, m_dout[i]);
      check($sformatf("%s.u%0d.chan_out", tag, i), c, m_chan[i]);
      check($sformatf("%s.u%0d.valid", tag, i), v, m_valid[i]);
      check($sformatf("%s.u%0d.wrap", tag, i), w, m_wrap[i]);
      check($sformatf("%s.u%0d.sel_err", tag, i), e, m_err[i]);
    end
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin : stim
    int exp_seq[14] = '{0,0,0,1,1,1,2,2,2,3,3,3,0,0};
    int held;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // manual sweep
    en = 1'b1; mode = 1'b0;
    data_bus = {$urandom, $urandom, $urandom, 32'h4433_2211};
    for (int s = 0; s < 4; s++) begin
      sel_bus = 4'(s);
      step("manual");
      check("manual.u0.data_exp", int'(dout0), 16'h11 * (s + 1));
      check("manual.u0.chan_exp", int'(chan0), s);
    end
    // 3-channel instance at sel=3 is the bad select
    check("badsel.u1.sel_err", int'(err1), 1);
    check("badsel.u1.valid", int'(val1), 0);
    check("badsel.u1.chan_held", int'(chan1), 2);
    check("badsel.u1.data_out", int'(dout1), 0);

    sel_bus = '0;
    step("manual0");

    // scan with wrap
    mode = 1'b1;
    for (int t = 0; t < 14; t++) begin
      step("scan");
      check($sformatf("scan.u0.seq%0d", t), int'(chan0), exp_seq[t]);
      check($sformatf("scan.u0.wrap%0d", t), int'(wr0), (t == 12) ? 1 : 0);
    end

    // run to chan 2 count 1, then hold
    for (int t = 0; t < 20 && !(m_chan[0] == 2 && m_cnt[0] == 1); t++) step("scan2");
    check("hold.reach", m_chan[0] * 10 + m_cnt[0], 21);
    hold = 1'b1;
    for (int t = 0; t < 5; t++) begin
      step("hold");
      check("hold.u0.chan", int'(chan0), 2);
    end
    hold = 1'b0;
    step("release");
    check("release.u0.chan", int'(chan0), 2);
    step("release");
    check("release.u0.adv", int'(chan0), 3);

    // reset mid-scan at chan 2
    for (int t = 0; t < 20 && m_chan[0] != 2; t++) step("scan3");
    check("rstmid.reach", int'(chan0), 2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    #2 rst_n = 1'b1;
    step("rst_resume");
    check("rst_resume.u0.chan", int'(chan0), 0);
    for (int t = 0; t < 3; t++) step("rst_scan");
    check("rst_scan.u0.chan", int'(chan0), 1);

    // en low during scan
    step("pre_en");
    held = int'(chan0);
    en = 1'b0;
    for (int t = 0; t < 4; t++) begin
      data_bus = {$urandom, $urandom, $urandom, $urandom};
      step("en_low");
      check("en_low.u0.valid", int'(val0), 0);
      check("en_low.u0.chan", int'(chan0), held);
    end
    en = 1'b1;
    for (int t = 0; t < 4; t++) step("en_back");

    // randomized traffic
    for (int t = 0; t < 400; t++) begin
      en   = ($urandom_range(0, 9) != 0);
      mode = ($urandom_range(0, 3) != 0);
      hold = ($urandom_range(0, 4) == 0);
      sel_bus = 4'($urandom_range(0, 15));
      data_bus = {$urandom, $urandom, $urandom, $urandom};
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
